// File: rtl/gf180mcu_fd_io__in_filt_pkg.sv
// Shared types and sizing helpers for the pad input filter.
// Imported by gf180mcu_fd_io__in_filt.
package gf180mcu_fd_io__in_filt_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } filt_state_e;

    localparam int GCNT_W = 8;

    // Qualification counter must hold DEB_CYCLES; never narrower than one bit.
    function automatic int cnt_width(input int deb_cycles);
        int w;
        w = $clog2(deb_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_io__sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
// Output is the last flop of the chain; all flops reset to RST_VAL.
module gf180mcu_fd_io__sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_io__in_filt.sv
// Pad input conditioner: synchroniser, debounce FSM, rise/fall event pulses.
// Optional glitch counter enabled by defining GF180MCU_FD_IO_GLITCH_CNT_EN.
module gf180mcu_fd_io__in_filt
    import gf180mcu_fd_io__in_filt_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_CYCLES  = 4,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              PAD_Y,
    input  logic              EN,
`ifdef GF180MCU_FD_IO_GLITCH_CNT_EN
    input  logic              GCNT_CLR,
    output logic [GCNT_W-1:0] GLITCH_CNT,
`endif
    output logic              Y_SYNC,
    output logic              Y_DEB,
    output logic              RISE,
    output logic              FALL
);

    localparam int CNT_W = cnt_width(DEB_CYCLES);

    logic y_sync;
    logic y_deb_reg, y_deb_next;
    logic rise_reg, rise_next;
    logic fall_reg, fall_next;
    logic reject;

    gf180mcu_fd_io__sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (RST_VAL)
    ) u_sync (
        .clk   (CLK),
        .rst_n (RN),
        .d     (PAD_Y),
        .q     (y_sync)
    );

    generate
        if (DEB_CYCLES == 0) begin : g_bypass
            // No qualification: follow the synchronised level whenever enabled.
            always_comb begin
                y_deb_next = y_deb_reg;
                rise_next  = 1'b0;
                fall_next  = 1'b0;
                reject     = 1'b0;
                if (EN) begin
                    y_deb_next = y_sync;
                    rise_next  = y_sync & ~y_deb_reg;
                    fall_next  = ~y_sync & y_deb_reg;
                end
            end
        end else begin : g_fsm
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

            filt_state_e      state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;

            always_ff @(posedge CLK or negedge RN) begin
                if (!RN) begin
                    state_reg <= STABLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                y_deb_next = y_deb_reg;
                rise_next  = 1'b0;
                fall_next  = 1'b0;
                reject     = 1'b0;
                if (!EN) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else begin
                    case (state_reg)
                        STABLE: begin
                            if (y_sync != y_deb_reg) begin
                                state_next = CHECK;
                                cnt_next   = CNT_W'(1);
                            end
                        end
                        CHECK: begin
                            if (y_sync == y_deb_reg) begin
                                // Level went back before qualifying: a glitch.
                                state_next = STABLE;
                                cnt_next   = '0;
                                reject     = 1'b1;
                            end else if (cnt_reg < CNT_MAX) begin
                                cnt_next = cnt_reg + CNT_W'(1);
                            end else begin
                                state_next = STABLE;
                                cnt_next   = '0;
                                y_deb_next = y_sync;
                                rise_next  = y_sync;
                                fall_next  = ~y_sync;
                            end
                        end
                        default: begin
                            state_next = STABLE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            y_deb_reg <= RST_VAL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            y_deb_reg <= y_deb_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    assign Y_SYNC = y_sync;
    assign Y_DEB  = y_deb_reg;
    assign RISE   = rise_reg;
    assign FALL   = fall_reg;

`ifdef GF180MCU_FD_IO_GLITCH_CNT_EN
    logic [GCNT_W-1:0] gcnt_reg, gcnt_next;

    // Clear has priority over a same-cycle rejection; count saturates.
    always_comb begin
        gcnt_next = gcnt_reg;
        if (GCNT_CLR) begin
            gcnt_next = '0;
        end else if (reject && (gcnt_reg != {GCNT_W{1'b1}})) begin
            gcnt_next = gcnt_reg + GCNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            gcnt_reg <= '0;
        end else begin
            gcnt_reg <= gcnt_next;
        end
    end

    assign GLITCH_CNT = gcnt_reg;
`else
    logic unused_reject;
    assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_io__in_filt.sv
// Self-checking bench: default instance (DEB_CYCLES=4) and bypass instance (DEB_CYCLES=0)
// share stimulus and are compared every cycle against a run-length model of the filter.
module tb_gf180mcu_fd_io__in_filt;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rn  = 1'b0;
    logic pad = 1'b1;
    logic en  = 1'b1;
    logic clr = 1'b0;

    logic ys [2];
    logic yd [2];
    logic ri [2];
    logic fa [2];
`ifdef GF180MCU_FD_IO_GLITCH_CNT_EN
    logic [7:0] gc [2];
`endif

    int compared   = 0;
    int mismatched = 0;

    int deb_cfg [2] = '{4, 0};
    int q [$];
    logic m_ys;
    logic m_yd [2];
    logic m_ri [2];
    logic m_fa [2];
    int   run  [2];
    int   m_gc [2];
    int   rise_seen [2];
    int   fall_seen [2];

    always #5 clk = ~clk;

    gf180mcu_fd_io__in_filt #(.SYNC_STAGES(S), .DEB_CYCLES(4), .RST_VAL(1'b0)) dut (
        .CLK(clk), .RN(rn), .PAD_Y(pad), .EN(en),
`ifdef GF180MCU_FD_IO_GLITCH_CNT_EN
        .GCNT_CLR(clr), .GLITCH_CNT(gc[0]),
`endif
        .Y_SYNC(ys[0]), .Y_DEB(yd[0]), .RISE(ri[0]), .FALL(fa[0])
    );

    gf180mcu_fd_io__in_filt #(.SYNC_STAGES(S), .DEB_CYCLES(0), .RST_VAL(1'b0)) dut_byp (
        .CLK(clk), .RN(rn), .PAD_Y(pad), .EN(en),
`ifdef GF180MCU_FD_IO_GLITCH_CNT_EN
        .GCNT_CLR(clr), .GLITCH_CNT(gc[1]),
`endif
        .Y_SYNC(ys[1]), .Y_DEB(yd[1]), .RISE(ri[1]), .FALL(fa[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: Y_SYNC is PAD_Y from S edges ago; Y_DEB flips once the synchronised
    // level has differed from it on DEB+1 consecutive enabled edges.
    task automatic model_step();
        logic ys_before;
        if (!rn) begin
            q.delete();
            m_ys = 1'b0;
            for (int i = 0; i < 2; i++) begin
                run[i] = 0; m_yd[i] = 1'b0; m_ri[i] = 1'b0; m_fa[i] = 1'b0; m_gc[i] = 0;
            end
        end else begin
            ys_before = m_ys;
            for (int i = 0; i < 2; i++) begin
                logic rej;
                rej = 1'b0;
                m_ri[i] = 1'b0;
                m_fa[i] = 1'b0;
                if (en && (ys_before != m_yd[i])) begin
                    run[i]++;
                    if (run[i] == deb_cfg[i] + 1) begin
                        m_yd[i] = ys_before;
                        m_ri[i] = ys_before;
                        m_fa[i] = ~ys_before;
                        run[i]  = 0;
                    end
                end else begin
                    rej    = en && (run[i] > 0);
                    run[i] = 0;
                end
                if (clr) m_gc[i] = 0;
                else if (rej && m_gc[i] < 255) m_gc[i]++;
            end
            q.push_back(int'(pad));
            if (q.size() > 8) void'(q.pop_front());
            m_ys = (q.size() >= S) ? logic'(q[q.size() - S]) : 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("y_sync[%0d]", i), ys[i], m_ys);
                check($sformatf("y_deb[%0d]", i), yd[i], m_yd[i]);
                check($sformatf("rise[%0d]", i), ri[i], m_ri[i]);
                check($sformatf("fall[%0d]", i), fa[i], m_fa[i]);
`ifdef GF180MCU_FD_IO_GLITCH_CNT_EN
                check($sformatf("glitch_cnt[%0d]", i), gc[i], m_gc[i]);
`endif
                if (ri[i] === 1'b1) rise_seen[i]++;
                if (fa[i] === 1'b1) fall_seen[i]++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 2; i++) begin
            rise_seen[i] = 0;
            fall_seen[i] = 0;
        end
    endtask

    // Edge number (start+1 onward) at which each instance first shows Y_DEB == val; 0 if never.
    task automatic wait_both(input logic val, input int start, input int maxc,
                             output int e0, output int e1);
        e0 = 0;
        e1 = 0;
        for (int n = start + 1; n <= start + maxc; n++) begin
            @(posedge clk);
            #2;
            if (e0 == 0 && yd[0] === val) e0 = n;
            if (e1 == 0 && yd[1] === val) e1 = n;
            if (e0 != 0 && e1 != 0) break;
        end
    endtask

    initial begin
        int e0, e1;
        clear_seen();

        // Reset held with pad high: everything at reset value.
        rn = 1'b0; pad = 1'b1; en = 1'b1; clr = 1'b0;
        tick(3);
        check("rst_y_sync", ys[0], 0);
        check("rst_y_deb", yd[0], 0);
        check("rst_rise", ri[0], 0);
        check("rst_fall", fa[0], 0);
`ifdef GF180MCU_FD_IO_GLITCH_CNT_EN
        check("rst_gcnt", gc[0], 0);
`endif
        rn = 1'b1;
        @(posedge clk); #2;
        check("rel_y_deb", yd[0], 0);
        check("rel_rise", ri[0], 0);
        check("rel_fall", fa[0], 0);
        wait_both(1'b1, 1, 20, e0, e1);
        check("rst_rise_latency", e0, 7);
        check("byp_rise_latency", e1, 3);
        tick(3);
        check("rst_rise_count", rise_seen[0], 1);
        check("rst_fall_count", fall_seen[0], 0);

        // Clean falling edge.
        clear_seen();
        pad = 1'b0;
        wait_both(1'b0, 0, 20, e0, e1);
        check("fall_latency", e0, 7);
        check("byp_fall_latency", e1, 3);
        tick(3);
        check("fall_count", fall_seen[0], 1);
        check("fall_rise_count", rise_seen[0], 0);

        // Three-cycle glitch: rejected by the filter, passed by the bypass.
        clear_seen();
        pad = 1'b1; tick(3);
        pad = 1'b0; tick(12);
        check("glitch3_y_deb", yd[0], 0);
        check("glitch3_rise", rise_seen[0], 0);
        check("glitch3_byp_rise", rise_seen[1], 1);
        check("glitch3_byp_fall", fall_seen[1], 1);
`ifdef GF180MCU_FD_IO_GLITCH_CNT_EN
        check("glitch3_gcnt", gc[0], 1);
        check("glitch3_byp_gcnt", gc[1], 0);
`endif

        // Boundary: four cycles rejected, five accepted.
        clear_seen();
        pad = 1'b1; tick(4);
        pad = 1'b0; tick(12);
        check("pulse4_rise", rise_seen[0], 0);
`ifdef GF180MCU_FD_IO_GLITCH_CNT_EN
        check("pulse4_gcnt", gc[0], 2);
`endif
        clear_seen();
        pad = 1'b1; tick(5);
        pad = 1'b0; tick(12);
        check("pulse5_rise", rise_seen[0], 1);
        check("pulse5_fall", fall_seen[0], 1);
        check("pulse5_y_deb", yd[0], 0);

        // Enable low freezes the debounced level.
        en = 1'b0; pad = 1'b1; tick(10);
        check("en0_y_sync", ys[0], 1);
        check("en0_y_deb", yd[0], 0);
        check("en0_byp_y_deb", yd[1], 0);
        clear_seen();
        en = 1'b1;
        wait_both(1'b1, 0, 20, e0, e1);
        check("en1_latency", e0, 5);
        check("en1_byp_latency", e1, 1);
        tick(3);
        check("en1_rise_count", rise_seen[0], 1);

        // Back low, then a long run of one-cycle glitches.
        pad = 1'b0; tick(12);
        for (int k = 0; k < 300; k++) begin
            pad = 1'b1; tick(1);
            pad = 1'b0; tick(1);
        end
        tick(4);
`ifdef GF180MCU_FD_IO_GLITCH_CNT_EN
        check("gcnt_saturated", gc[0], 255);
`endif
        // Clear held across two edges, one of which is a rejection.
        pad = 1'b1; tick(1);
        pad = 1'b0; tick(1);
        clr = 1'b1;
        pad = 1'b1; tick(1);
        pad = 1'b0; tick(1);
`ifdef GF180MCU_FD_IO_GLITCH_CNT_EN
        check("gcnt_clear_wins", gc[0], 0);
`endif
        clr = 1'b0;
        tick(12);

        // Reset in mid-qualification: immediate reset values, no pulse.
        clear_seen();
        pad = 1'b1; tick(4);
        rn = 1'b0;
        #1;
        check("midrst_y_sync", ys[0], 0);
        check("midrst_y_deb", yd[0], 0);
        check("midrst_rise", ri[0], 0);
        tick(2);
        rn = 1'b1;
        tick(3);
        check("midrst_rise_count", rise_seen[0], 0);
        check("midrst_fall_count", fall_seen[0], 0);
        tick(10);
        check("postrst_y_deb", yd[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
